// File: rtl/sys_types.sv
// Shared types for the window loader datapath.
//   int8_t      : signed 8-bit pixel at the default pixel width
//   load_mode_e : window build mode sampled with start
//   ld_state_e  : loader FSM state
package sys_types;

    typedef logic signed [7:0] int8_t;

    typedef enum logic {
        MODE_FULL  = 1'b0,
        MODE_SHIFT = 1'b1
    } load_mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StLoad = 1'b1
    } ld_state_e;

endpackage

// File: rtl/window_row_loader.sv
// Builds an N x N pixel window from a row stream, one row per accepted
// ready/valid beat. FULL reloads every row; SHIFT slides the window down one
// image row and loads only the new bottom row.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start, mode  : build request (taken only in idle) and its mode (0 FULL, 1 SHIFT)
//   row_valid    : row_data carries a row
//   row_ready    : loader accepts a row this cycle
//   row_data     : one row, column 0 in the MSBs
//   win_data     : window, pixel (r,c) at [(r*N+c)*PIX_W +: PIX_W]
//   row_loaded   : one-hot pulse, bit r the cycle after row r is written
//   win_valid    : window complete and stable
//   busy         : build in progress
//   done         : one-cycle completion pulse
module window_row_loader
    import sys_types::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned PIX_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [N*PIX_W-1:0]     row_data,
    output logic [N*N*PIX_W-1:0]   win_data,
    output logic [N-1:0]           row_loaded,
    output logic                   win_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned ROW_W = N * PIX_W;
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

    ld_state_e        r_state;
    ld_state_e        w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [PIX_W-1:0] r_pix [N][N];
    logic [N-1:0]     r_row_loaded;
    logic             r_win_valid;
    logic             r_done;

    logic w_accept;
    logic w_take_start;
    logic w_do_shift;
    logic w_last;

    always_comb begin
        w_state_next = r_state;
        w_take_start = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_do_shift   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_take_start = start;
                // SHIFT without a complete window falls back to a full reload
                w_do_shift   = start && (load_mode_e'(mode) == MODE_SHIFT) && r_win_valid;
                if (start) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_accept = row_valid;
                w_last   = row_valid && (r_idx == LastIdx);
                if (w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_row_loaded <= '0;
            r_win_valid  <= 1'b0;
            r_done       <= 1'b0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    r_pix[r][c] <= '0;
                end
            end
        end else begin
            r_state      <= w_state_next;
            r_row_loaded <= '0;
            r_done       <= 1'b0;

            if (w_take_start) begin
                r_win_valid <= 1'b0;
                r_idx       <= w_do_shift ? LastIdx : '0;
                if (w_do_shift) begin
                    for (int unsigned r = 0; r + 1 < N; r++) begin
                        r_pix[r] <= r_pix[r+1];
                    end
                end
            end

            if (w_accept) begin
                for (int unsigned c = 0; c < N; c++) begin
                    r_pix[r_idx][c] <= row_data[(N-1-c)*PIX_W +: PIX_W];
                end
                r_row_loaded <= {{(N-1){1'b0}}, 1'b1} << r_idx;
                if (w_last) begin
                    // Index parks at N-1 rather than wrapping
                    r_done      <= 1'b1;
                    r_win_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign win_data[gr*ROW_W + gc*PIX_W +: PIX_W] = r_pix[gr][gc];
        end
    end

    assign busy       = (r_state == StLoad);
    assign row_ready  = (r_state == StLoad);
    assign row_loaded = r_row_loaded;
    assign win_valid  = r_win_valid;
    assign done       = r_done;

endmodule

// File: tb/tb_window_row_loader.sv
module tb_window_row_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic         row_valid;
    logic         row_ready;
    logic [31:0]  row_data;
    logic [127:0] win_data;
    logic [3:0]   row_loaded;
    logic         win_valid;
    logic         busy;
    logic         done;

    logic         start3;
    logic         row_valid3;
    logic         row_ready3;
    logic [47:0]  row_data3;
    logic [143:0] win_data3;
    logic [2:0]   row_loaded3;
    logic         win_valid3;
    logic         busy3;
    logic         done3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    window_row_loader #(.N(4), .PIX_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .win_data   (win_data),
        .row_loaded (row_loaded),
        .win_valid  (win_valid),
        .busy       (busy),
        .done       (done)
    );

    window_row_loader #(.N(3), .PIX_W(16)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start3),
        .mode       (1'b0),
        .row_valid  (row_valid3),
        .row_ready  (row_ready3),
        .row_data   (row_data3),
        .win_data   (win_data3),
        .row_loaded (row_loaded3),
        .win_valid  (win_valid3),
        .busy       (busy3),
        .done       (done3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({win_data, row_loaded, win_valid, busy, done, row_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b/%b%b%b%b want all zero",
                     win_data, row_loaded, win_valid, busy, done, row_ready);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({busy, row_ready, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got %b want 000", {busy, row_ready, done});
        end
    endtask

    task automatic test_full;
        logic [31:0] rows [4];
        rows[0] = 32'h03020100;
        rows[1] = 32'h07060504;
        rows[2] = 32'h0B0A0908;
        rows[3] = 32'h0F0E0D0C;
        start = 1'b1; mode = 1'b0; row_valid = 1'b1; row_data = rows[0];
        tick();
        start = 1'b0;
        total++;
        if ({busy, row_ready, row_loaded} !== 6'b11_0000) begin
            bad++;
            $display("FAIL full_start: got %b want 110000", {busy, row_ready, row_loaded});
        end
        for (int i = 0; i < 4; i++) begin
            row_data = rows[i];
            tick();
            total++;
            if (row_loaded !== (4'b0001 << i) || done !== (i == 3) || win_valid !== (i == 3)) begin
                bad++;
                $display("FAIL full_row%0d: got loaded=%b done=%b wv=%b want loaded=%b done=%b",
                         i, row_loaded, done, win_valid, 4'b0001 << i, (i == 3));
            end
        end
        row_valid = 1'b0;
        total++;
        if (win_data !== 128'h0C0D0E0F_08090A0B_04050607_00010203) begin
            bad++;
            $display("FAIL full_window: got %h want %h", win_data,
                     128'h0C0D0E0F_08090A0B_04050607_00010203);
        end
        total++;
        if (win_data[7:0] !== 8'h03 || win_data[127:120] !== 8'h0C) begin
            bad++;
            $display("FAIL full_pixels: got p00=%h p33=%h want 03 0c",
                     win_data[7:0], win_data[127:120]);
        end
        tick();
        total++;
        if ({done, win_valid, busy, row_ready} !== 4'b0100) begin
            bad++;
            $display("FAIL full_after: got %b want 0100", {done, win_valid, busy, row_ready});
        end
    endtask

    task automatic test_shift;
        start = 1'b1; mode = 1'b1; row_valid = 1'b1; row_data = 32'h13121110;
        tick();
        start = 1'b0; mode = 1'b0;
        total++;
        if (win_data[31:0] !== 32'h04050607 || busy !== 1'b1 || win_valid !== 1'b0
            || row_loaded !== 4'b0000) begin
            bad++;
            $display("FAIL shift_edge: got row0=%h busy=%b wv=%b loaded=%b want 04050607 1 0 0000",
                     win_data[31:0], busy, win_valid, row_loaded);
        end
        tick();
        row_valid = 1'b0;
        total++;
        if (row_loaded !== 4'b1000 || done !== 1'b1 || win_valid !== 1'b1) begin
            bad++;
            $display("FAIL shift_done: got loaded=%b done=%b wv=%b want 1000 1 1",
                     row_loaded, done, win_valid);
        end
        total++;
        if (win_data !== 128'h10111213_0C0D0E0F_08090A0B_04050607) begin
            bad++;
            $display("FAIL shift_window: got %h want %h", win_data,
                     128'h10111213_0C0D0E0F_08090A0B_04050607);
        end
        tick();
    endtask

    task automatic test_shift_after_reset;
        logic [31:0] rows [4];
        rows[0] = 32'h21222324;
        rows[1] = 32'h31323334;
        rows[2] = 32'h41424344;
        rows[3] = 32'h51525354;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1; mode = 1'b1; row_valid = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row_data = rows[i];
            tick();
            total++;
            if (row_loaded !== (4'b0001 << i) || done !== (i == 3)) begin
                bad++;
                $display("FAIL promote_row%0d: got loaded=%b done=%b want loaded=%b done=%b",
                         i, row_loaded, done, 4'b0001 << i, (i == 3));
            end
        end
        row_valid = 1'b0;
        total++;
        if (win_data !== 128'h54535251_44434241_34333231_24232221) begin
            bad++;
            $display("FAIL promote_window: got %h want %h", win_data,
                     128'h54535251_44434241_34333231_24232221);
        end
        tick();
    endtask

    task automatic test_stall;
        logic [31:0] rows [4];
        rows[0] = 32'hA0A1A2A3;
        rows[1] = 32'hB0B1B2B3;
        rows[2] = 32'hC0C1C2C3;
        rows[3] = 32'hD0D1D2D3;
        start = 1'b1; mode = 1'b0; row_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            row_data = rows[i];
            tick();
        end
        total++;
        if (row_loaded !== 4'b0010) begin
            bad++;
            $display("FAIL stall_pre: got %b want 0010", row_loaded);
        end
        row_valid = 1'b0;
        row_data  = 32'hEEEEEEEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (row_ready !== 1'b1 || row_loaded !== 4'b0000 || done !== 1'b0) begin
                bad++;
                $display("FAIL stall_cyc%0d: got ready=%b loaded=%b done=%b want 1 0000 0",
                         i, row_ready, row_loaded, done);
            end
        end
        row_valid = 1'b1;
        row_data  = rows[2];
        tick();
        total++;
        if (row_loaded !== 4'b0100 || done !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume: got loaded=%b done=%b want 0100 0", row_loaded, done);
        end
        row_data = rows[3];
        tick();
        row_valid = 1'b0;
        total++;
        if (row_loaded !== 4'b1000 || done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: got loaded=%b done=%b want 1000 1", row_loaded, done);
        end
        total++;
        if (win_data !== 128'hD3D2D1D0_C3C2C1C0_B3B2B1B0_A3A2A1A0) begin
            bad++;
            $display("FAIL stall_window: got %h want %h", win_data,
                     128'hD3D2D1D0_C3C2C1C0_B3B2B1B0_A3A2A1A0);
        end
        tick();
    endtask

    task automatic test_busy_reset;
        start = 1'b1; mode = 1'b0; row_valid = 1'b1; row_data = 32'h11111111;
        tick();
        start = 1'b0;
        tick();
        // start while busy, during a stall cycle
        start = 1'b1; row_valid = 1'b0;
        tick();
        start = 1'b0; row_valid = 1'b1; row_data = 32'h22222222;
        tick();
        total++;
        if (row_loaded !== 4'b0010 || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_start_ignored: got loaded=%b busy=%b want 0010 1",
                     row_loaded, busy);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({win_data, busy, win_valid, done, row_ready, row_loaded} !== '0) begin
            bad++;
            $display("FAIL abort_reset: got win=%h busy=%b wv=%b done=%b ready=%b want all zero",
                     win_data, busy, win_valid, done, row_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_nodone%0d: got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        row_valid = 1'b0;
    endtask

    task automatic test_n3_w16;
        logic [47:0] rows [3];
        rows[0] = 48'h1000_1001_1002;
        rows[1] = 48'h2000_2001_2002;
        rows[2] = 48'h3000_3001_3002;
        start3 = 1'b1; row_valid3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            row_data3 = rows[i];
            tick();
            total++;
            if (row_loaded3 !== (3'b001 << i) || done3 !== (i == 2)) begin
                bad++;
                $display("FAIL n3_row%0d: got loaded=%b done=%b want loaded=%b done=%b",
                         i, row_loaded3, done3, 3'b001 << i, (i == 2));
            end
        end
        row_valid3 = 1'b0;
        total++;
        if (win_data3[127:112] !== 16'h3001 || win_data3[15:0] !== 16'h1000
            || win_data3[143:128] !== 16'h3002) begin
            bad++;
            $display("FAIL n3_pixels: got p21=%h p00=%h p22=%h want 3001 1000 3002",
                     win_data3[127:112], win_data3[15:0], win_data3[143:128]);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; row_valid = 1'b0; row_data = '0;
        start3 = 1'b0; row_valid3 = 1'b0; row_data3 = '0;
        test_reset();
        test_full();
        test_shift();
        test_shift_after_reset();
        test_stall();
        test_busy_reset();
        test_n3_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
